cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Common Data Bus arbiter for the Tomasulo core. Collects completed results from NUM_FU functional units and grants one per cycle with round-robin priority. Registers the winner onto the single CDB broadcast (cdb_valid/cdb_tag/cdb_data) consumed by the register status table and the reservation stations. Losing units are back-pressured through a valid/ready handshake.

Parameters:
NUM_FU, 4, number of requesting functional units (2..8)
TAG_WIDTH, 4, RS tag width; tag value 0 = TAG_NONE
DATA_WIDTH, 32, result width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous squash: drop pending broadcast, refuse requests this cycle
fu_valid  input  NUM_FU  per-FU result request
fu_tag  input  NUM_FU*TAG_WIDTH  per-FU tag, FU i at [i*TAG_WIDTH +: TAG_WIDTH]
fu_data  input  NUM_FU*DATA_WIDTH  per-FU result, FU i at [i*DATA_WIDTH +: DATA_WIDTH]
fu_ready  output  NUM_FU  one-hot accept; transfer when fu_valid[i] && fu_ready[i]
cdb_valid  output  1  broadcast valid, one-cycle pulse per accepted result
cdb_tag  output  TAG_WIDTH  broadcast producer tag
cdb_data  output  DATA_WIDTH  broadcast value
cdb_src  output  3  index of FU that produced current broadcast
err_tag_none  output  1  sticky: a request with tag 0 was accepted

Behaviour:
- Reset (rst=1 at clk edge): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, err_tag_none=0, rr_ptr=0 (FU0 highest priority). fu_ready forced 0 while rst=1.
- Grant is combinational. Search fu_valid starting at rr_ptr, ascending with wrap at NUM_FU-1 -> 0. The first valid FU wins. fu_ready = one-hot(winner) when any valid and !flush and !rst, else 0.
- fu_ready never asserts for an FU whose fu_valid=0. At most one bit is set.
- FU handshake rule: once fu_valid rises, the FU holds valid, tag and data stable until accepted. The arbiter never drops a request silently.
- Latency: 1 cycle. An accept in cycle N gives cdb_valid=1 in cycle N+1 with the captured tag, data and src index.
- No accept in cycle N gives cdb_valid=0 in N+1. cdb_tag, cdb_data and cdb_src hold their last values (don't-care to consumers).
- rr_ptr update on accept: rr_ptr <= (winner+1) mod NUM_FU. With no accept, rr_ptr is unchanged.
- Full throughput: one broadcast per cycle, back-to-back, no bubbles while any fu_valid is set. The CDB is never stalled by consumers.
- Tag 0 request: accepted normally (handshake completes, rr_ptr advances). cdb_valid stays 0 for that slot. err_tag_none sets and holds until rst.
- flush=1 in cycle N: fu_ready=0 in N, cdb_valid=0 in N+1, and the registered broadcast from an accept in N-1 is suppressed. rr_ptr is unchanged.
- Reset mid-operation: the pending broadcast is discarded. Requesters stay un-accepted and re-arbitrate after reset from FU0.
- Fairness bound: any continuously valid FU is accepted within NUM_FU cycles.

Optional Feature:
CDB_STATS_EN
- Defined: adds outputs stat_bcast (32-bit count of cdb_valid cycles) and stat_conflict (32-bit count of cycles with two or more fu_valid bits set and an accept). Both counters saturate at all-ones and clear on rst. They do not count during flush.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles with fu_valid=4'b1111 -> fu_ready=0 throughout. Release -> first accept is FU0. Next cycle cdb_valid=1, cdb_src=0.
- Single request: FU2 valid, tag=5, data=0xDEAD_BEEF -> fu_ready=4'b0100 same cycle. Next cycle cdb_valid=1, cdb_tag=5, cdb_data=0xDEADBEEF, cdb_src=2, then 0.
- Round robin: all 4 FUs valid continuously from rr_ptr=0 (tags 1..4) -> accept order FU0,1,2,3,0. Five consecutive cdb_valid pulses with tags 1,2,3,4,1 and no gaps.
- Pointer wrap: rr_ptr=3, FU1 and FU3 valid -> FU3 accepted, then FU1. rr_ptr goes 3 -> 0 -> 2.
- Flush: FU0 accepted in cycle N, flush=1 in N+1 with FU1 valid -> cdb_valid=0 in N+1 and N+2, fu_ready=0 in N+1. FU1 accepted in N+2 and broadcast in N+3.
- Tag 0: FU1 valid with tag=0 -> fu_ready[1]=1, next cycle cdb_valid=0, err_tag_none=1 and held until rst.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant of one FU result per cycle onto the registered CDB.
// Optional statistics counters are enabled with `define CDB_STATS_EN.
module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [NUM_FU-1:0]                fu_valid,
    input  logic [NUM_FU*TAG_WIDTH-1:0]      fu_tag,
    input  logic [NUM_FU*DATA_WIDTH-1:0]     fu_data,
    output logic [NUM_FU-1:0]                fu_ready,
    output logic                             cdb_valid,
    output logic [TAG_WIDTH-1:0]             cdb_tag,
    output logic [DATA_WIDTH-1:0]            cdb_data,
    output logic [2:0]                       cdb_src,
    output logic                             err_tag_none
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]                      stat_bcast,
    output logic [31:0]                      stat_conflict
`endif
);

    logic [2:0]            rr_ptr;
    logic [2:0]            winner;
    logic                  found;
    logic                  accept;
    logic                  bcast_q;
    logic [TAG_WIDTH-1:0]  win_tag;
    logic [DATA_WIDTH-1:0] win_data;
    logic [3:0]            next_ptr;

    // Rotating priority search: candidate k is (rr_ptr + k) mod NUM_FU.
    always_comb begin
        logic [3:0] sum;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, rr_ptr} + 4'(k);
            if (sum >= 4'(NUM_FU)) begin
                sum = sum - 4'(NUM_FU);
            end
            for (int j = 0; j < NUM_FU; j++) begin
                if (!found && sum[2:0] == 3'(j) && fu_valid[j]) begin
                    found  = 1'b1;
                    winner = 3'(j);
                end
            end
        end
    end

    always_comb begin
        win_tag  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (winner == 3'(i)) begin
                win_tag  = fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
                win_data = fu_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept = found && !flush && !rst;

    always_comb begin
        fu_ready = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = accept && (winner == 3'(i));
        end
    end

    assign next_ptr = ({1'b0, winner} + 4'd1 >= 4'(NUM_FU)) ? 4'd0 : {1'b0, winner} + 4'd1;

    // Flush and reset both kill a broadcast that is already sitting in the output register.
    assign cdb_valid = bcast_q && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_q      <= 1'b0;
            cdb_tag      <= '0;
            cdb_data     <= '0;
            cdb_src      <= '0;
            err_tag_none <= 1'b0;
            rr_ptr       <= '0;
        end else begin
            bcast_q <= accept && (win_tag != '0);
            if (accept) begin
                cdb_tag  <= win_tag;
                cdb_data <= win_data;
                cdb_src  <= winner;
                rr_ptr   <= next_ptr[2:0];
                if (win_tag == '0) begin
                    err_tag_none <= 1'b1;
                end
            end
        end
    end

`ifdef CDB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bcast    <= '0;
            stat_conflict <= '0;
        end else begin
            if (cdb_valid && stat_bcast != '1) begin
                stat_bcast <= stat_bcast + 32'd1;
            end
            if (accept && $countones(fu_valid) >= 2 && stat_conflict != '1) begin
                stat_conflict <= stat_conflict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed plan scenarios plus randomized traffic
// compared every cycle against a queue-free behavioural model of the arbitration rules.
module tb_cdb_arbiter;

   localparam int NUM_FU     = 4;
   localparam int TAG_WIDTH  = 4;
   localparam int DATA_WIDTH = 32;

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          flush;
   logic [NUM_FU-1:0]             fu_valid;
   logic [NUM_FU*TAG_WIDTH-1:0]   fu_tag;
   logic [NUM_FU*DATA_WIDTH-1:0]  fu_data;
   logic [NUM_FU-1:0]             fu_ready;
   logic                          cdb_valid;
   logic [TAG_WIDTH-1:0]          cdb_tag;
   logic [DATA_WIDTH-1:0]         cdb_data;
   logic [2:0]                    cdb_src;
   logic                          err_tag_none;

   cdb_arbiter #(
      .NUM_FU(NUM_FU),
      .TAG_WIDTH(TAG_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .fu_valid(fu_valid),
      .fu_tag(fu_tag),
      .fu_data(fu_data),
      .fu_ready(fu_ready),
      .cdb_valid(cdb_valid),
      .cdb_tag(cdb_tag),
      .cdb_data(cdb_data),
      .cdb_src(cdb_src),
      .err_tag_none(err_tag_none)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   int                    mPtr = 0;
   bit                    mBcast = 1'b0;
   logic [TAG_WIDTH-1:0]  mTag = '0;
   logic [DATA_WIDTH-1:0] mData = '0;
   int                    mSrc = 0;
   bit                    mErr = 1'b0;
   bit                    modelLive = 1'b0;
   int                    lastAccept = -1;

   bit                    pend [NUM_FU];
   logic [TAG_WIDTH-1:0]  pTag [NUM_FU];
   logic [DATA_WIDTH-1:0] pData [NUM_FU];

   // First requesting FU when scanning upward from the priority pointer, -1 if none.
   function automatic int expWinner();
      for (int i = 0; i < NUM_FU; i++) begin
         int j;
         j = (mPtr + i) % NUM_FU;
         if (fu_valid[j]) return j;
      end
      return -1;
   endfunction

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare all DUT outputs against the model for the current cycle's inputs.
   task automatic checkOutput();
      int w;
      logic [63:0] expReady;
      bit expValid;
      w = expWinner();
      expReady = (w >= 0 && !flush && !rst) ? (64'd1 << w) : 64'd0;
      checkVal("fu_ready", 64'(fu_ready), expReady);
      expValid = mBcast && !flush && !rst;
      checkVal("cdb_valid", 64'(cdb_valid), 64'(expValid));
      if (expValid) begin
         checkVal("cdb_tag", 64'(cdb_tag), 64'(mTag));
         checkVal("cdb_data", 64'(cdb_data), 64'(mData));
         checkVal("cdb_src", 64'(cdb_src), 64'(mSrc));
      end
      if (modelLive) begin
         checkVal("err_tag_none", 64'(err_tag_none), 64'(mErr));
      end
   endtask

   task automatic applyStimulus(input logic rstI, input logic flushI, input logic [NUM_FU-1:0] v,
                                input logic [NUM_FU*TAG_WIDTH-1:0] tags,
                                input logic [NUM_FU*DATA_WIDTH-1:0] datas);
      rst      = rstI;
      flush    = flushI;
      fu_valid = v;
      fu_tag   = tags;
      fu_data  = datas;
      #4;
      checkOutput();
   endtask

   // Advance one clock and let the model take the same edge the DUT just saw.
   task automatic tick();
      int w;
      @(posedge clk);
      lastAccept = -1;
      if (rst) begin
         mPtr = 0;
         mBcast = 1'b0;
         mTag = '0;
         mData = '0;
         mSrc = 0;
         mErr = 1'b0;
         modelLive = 1'b1;
      end else begin
         w = expWinner();
         if (w >= 0 && !flush) begin
            lastAccept = w;
            mTag   = fu_tag[w*TAG_WIDTH +: TAG_WIDTH];
            mData  = fu_data[w*DATA_WIDTH +: DATA_WIDTH];
            mSrc   = w;
            mBcast = (mTag != '0);
            if (mTag == '0) mErr = 1'b1;
            mPtr = (w + 1) % NUM_FU;
         end else begin
            mBcast = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      logic [NUM_FU*TAG_WIDTH-1:0]  tv;
      logic [NUM_FU*DATA_WIDTH-1:0] dv;
      logic [NUM_FU-1:0]            vv;

      // Reset held two cycles with every FU requesting.
      applyStimulus(1'b1, 1'b0, 4'b1111, 16'h4321, '0);
      checkVal("reset_ready_c0", 64'(fu_ready), 64'd0);
      tick();
      applyStimulus(1'b1, 1'b0, 4'b1111, 16'h4321, '0);
      checkVal("reset_ready_c1", 64'(fu_ready), 64'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 4'b1111, 16'h4321, '0);
      checkVal("reset_tag", 64'(cdb_tag), 64'd0);
      checkVal("reset_data", 64'(cdb_data), 64'd0);
      checkVal("reset_src", 64'(cdb_src), 64'd0);
      checkVal("reset_err", 64'(err_tag_none), 64'd0);
      checkVal("first_grant_fu0", 64'(fu_ready), 64'h1);
      tick();

      // Round robin with all four requesting: broadcasts carry tags 2,3,4,1 after tag 1.
      applyStimulus(1'b0, 1'b0, 4'b1111, 16'h4321, '0);
      checkVal("rr_bc0_src", 64'(cdb_src), 64'd0);
      checkVal("rr_bc0_tag", 64'(cdb_tag), 64'd1);
      checkVal("rr_ready1", 64'(fu_ready), 64'h2);
      tick();
      for (int k = 2; k <= 4; k++) begin
         applyStimulus(1'b0, 1'b0, 4'b1111, 16'h4321, '0);
         checkVal("rr_valid", 64'(cdb_valid), 64'd1);
         checkVal("rr_tag", 64'(cdb_tag), 64'(k));
         tick();
      end
      applyStimulus(1'b0, 1'b0, 4'b0000, 16'h4321, '0);
      checkVal("rr_bc4_tag", 64'(cdb_tag), 64'd1);
      checkVal("rr_bc4_valid", 64'(cdb_valid), 64'd1);
      tick();

      // Single request from FU2 (pointer now at FU1).
      dv = '0;
      dv[2*DATA_WIDTH +: DATA_WIDTH] = 32'hDEAD_BEEF;
      applyStimulus(1'b0, 1'b0, 4'b0100, 16'h0500, dv);
      checkVal("single_ready", 64'(fu_ready), 64'h4);
      tick();
      applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
      checkVal("single_valid", 64'(cdb_valid), 64'd1);
      checkVal("single_tag", 64'(cdb_tag), 64'd5);
      checkVal("single_data", 64'(cdb_data), 64'hDEADBEEF);
      checkVal("single_src", 64'(cdb_src), 64'd2);
      tick();
      applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
      checkVal("single_after", 64'(cdb_valid), 64'd0);
      tick();

      // Pointer wrap: pointer at FU3, FU1 and FU3 requesting.
      applyStimulus(1'b0, 1'b0, 4'b1010, 16'h7060, '0);
      checkVal("wrap_ready3", 64'(fu_ready), 64'h8);
      tick();
      applyStimulus(1'b0, 1'b0, 4'b0010, 16'h0060, '0);
      checkVal("wrap_ready1", 64'(fu_ready), 64'h2);
      checkVal("wrap_src3", 64'(cdb_src), 64'd3);
      tick();
      applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
      checkVal("wrap_src1", 64'(cdb_src), 64'd1);
      tick();

      // Flush: FU0 accepted in N, flush in N+1 with FU1 waiting.
      applyStimulus(1'b0, 1'b0, 4'b0001, 16'h0008, '0);
      checkVal("flush_acc0", 64'(fu_ready), 64'h1);
      tick();
      applyStimulus(1'b0, 1'b1, 4'b0010, 16'h0090, '0);
      checkVal("flush_ready", 64'(fu_ready), 64'd0);
      checkVal("flush_kill", 64'(cdb_valid), 64'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 4'b0010, 16'h0090, '0);
      checkVal("flush_after", 64'(cdb_valid), 64'd0);
      checkVal("flush_acc1", 64'(fu_ready), 64'h2);
      tick();
      applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
      checkVal("flush_bc1", 64'(cdb_valid), 64'd1);
      checkVal("flush_bc1_tag", 64'(cdb_tag), 64'd9);
      tick();

      // Tag 0 request from FU1.
      applyStimulus(1'b0, 1'b0, 4'b0010, 16'h0000, '0);
      checkVal("tag0_ready", 64'(fu_ready), 64'h2);
      tick();
      applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
      checkVal("tag0_valid", 64'(cdb_valid), 64'd0);
      checkVal("tag0_err", 64'(err_tag_none), 64'd1);
      tick();
      applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
      checkVal("tag0_err_hold", 64'(err_tag_none), 64'd1);
      tick();

      // Randomized traffic with FUs that obey the hold-until-accepted handshake.
      for (int i = 0; i < NUM_FU; i++) begin
         pend[i] = 1'b0;
         pTag[i] = '0;
         pData[i] = '0;
      end
      repeat (2000) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i]  = 1'b1;
               pTag[i]  = TAG_WIDTH'($urandom_range(0, 15));
               pData[i] = $urandom;
            end
            vv[i] = pend[i];
            tv[i*TAG_WIDTH +: TAG_WIDTH] = pTag[i];
            dv[i*DATA_WIDTH +: DATA_WIDTH] = pData[i];
         end
         applyStimulus(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) == 0), vv, tv, dv);
         tick();
         if (lastAccept >= 0) pend[lastAccept] = 1'b0;
      end

      // Reset clears the sticky error and the broadcast.
      applyStimulus(1'b1, 1'b0, 4'b0000, '0, '0);
      tick();
      applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0);
      checkVal("final_err", 64'(err_tag_none), 64'd0);
      checkVal("final_valid", 64'(cdb_valid), 64'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
